// File: rtl/riscv_pkg.sv
// Shared fetch/decode definitions: fetch FSM states, the canonical NOP and the
// base-ISA opcode values the decoders match against.
package riscv_pkg;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory port: one valid/ready request channel and a response channel.
interface instruction_fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/fetch_pc_gen.sv
// Combinational next-PC select for the fetch stage: redirect beats sequential
// advance, which beats hold. Redirect targets are forced to word alignment.
module fetch_pc_gen #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic            redirect_en,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            advance,
  output logic [XLEN-1:0] pc_next,
  output logic [XLEN-1:0] pc_plus4,
  output logic            misalign
);

  always_comb begin
    pc_plus4 = pc + XLEN'(4);
    misalign = 1'b0;
    pc_next  = pc;
    if (redirect_en) begin
      pc_next  = {redirect_target[XLEN-1:2], 2'b00};
      misalign = (redirect_target[1:0] != 2'b00);
    end else if (advance) begin
      pc_next = pc_plus4;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: keeps the PC, issues one outstanding instruction-memory request
// at a time and hands each fetched word, pre-split into fields, to the decoder.
module instruction_fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  instruction_fetch_unit_if.master imem,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_target,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [31:0]              instr,
  output logic [6:0]               op,
  output logic [2:0]               funct3,
  output logic [6:0]               funct7,
  output logic [XLEN-1:0]          pc_out,
  output logic [XLEN-1:0]          pc_plus4,
  output logic                     misalign_err,
  output logic [31:0]              fetch_count
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [31:0]     count_q, count_d;
  logic            drop_q, drop_d;
  logic            misalign_q, misalign_d;
  logic            req_valid_q, req_valid_d;
  logic            instr_valid_q, instr_valid_d;
  logic            redirect_en;
  logic            advance;

  assign redirect_en = redirect_valid && (state_q != S_RESET);
  assign advance     = (state_q == S_HOLD) && instr_ready;

  fetch_pc_gen #(.XLEN(XLEN)) u_pc_gen (
    .pc              (pc_q),
    .redirect_en     (redirect_en),
    .redirect_target (redirect_target),
    .advance         (advance),
    .pc_next         (pc_d),
    .pc_plus4        (pc_plus4),
    .misalign        (misalign_d)
  );

  // drop marks an accepted request whose response has been made stale by a redirect
  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    instr_d = instr_q;
    count_d = count_q;
    case (state_q)
      S_RESET: state_d = S_REQ;
      S_REQ: begin
        if (imem.imem_req_ready) begin
          state_d = S_WAIT;
          drop_d  = redirect_en;
        end
      end
      S_WAIT: begin
        if (imem.imem_rsp_valid) begin
          drop_d = 1'b0;
          if (drop_q || redirect_en) begin
            state_d = S_REQ;
          end else begin
            instr_d = imem.imem_rsp_data;
            state_d = S_HOLD;
          end
        end else if (redirect_en) begin
          drop_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (instr_ready || redirect_en) state_d = S_REQ;
        if (instr_ready) count_d = count_q + 32'd1;
      end
      default: state_d = S_RESET;
    endcase
    req_valid_d   = (state_d == S_REQ);
    instr_valid_d = (state_d == S_HOLD);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_RESET;
      pc_q          <= RESET_PC;
      instr_q       <= NOP_INSTR;
      count_q       <= '0;
      drop_q        <= 1'b0;
      misalign_q    <= 1'b0;
      req_valid_q   <= 1'b0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      count_q       <= count_d;
      drop_q        <= drop_d;
      misalign_q    <= misalign_d;
      req_valid_q   <= req_valid_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign imem.imem_req_valid = req_valid_q;
  assign imem.imem_addr      = pc_q;
  assign instr_valid         = instr_valid_q;
  assign instr               = instr_q;
  assign op                  = instr_q[6:0];
  assign funct3              = instr_q[14:12];
  assign funct7              = instr_q[31:25];
  assign pc_out              = pc_q;
  assign misalign_err        = misalign_q;
  assign fetch_count         = count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: a vector table for steady
// fetching, directed multi-cycle sequences, and random traffic against a model.
module tb_instruction_fetch_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        instr_ready;
  logic        instr_valid;
  logic [31:0] instr;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        misalign_err;
  logic [31:0] fetch_count;

  int errors = 0;
  int checks = 0;

  instruction_fetch_unit_if #(.XLEN(32)) imem_bus ();

  instruction_fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem            (imem_bus),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .op              (op),
    .funct3          (funct3),
    .funct7          (funct7),
    .pc_out          (pc_out),
    .pc_plus4        (pc_plus4),
    .misalign_err    (misalign_err),
    .fetch_count     (fetch_count)
  );

  always #5 clk = ~clk;

  // Reference model: tracks whether fetching has begun, whether a request is
  // in flight (and whether its answer is already stale), and whether an
  // instruction is waiting for the decoder.
  logic        m_started, m_in_flight, m_stale, m_holding, m_mis;
  logic [31:0] m_pc, m_instr, m_count;

  task automatic model_reset();
    m_started   = 1'b0;
    m_in_flight = 1'b0;
    m_stale     = 1'b0;
    m_holding   = 1'b0;
    m_mis       = 1'b0;
    m_pc        = 32'h0;
    m_instr     = NOP_INSTR;
    m_count     = 32'h0;
  endtask

  task automatic model_step();
    logic asking, accepted, handed_off, redir;
    if (!rst) return;
    if (!m_started) begin
      m_started = 1'b1;
      m_mis     = 1'b0;
      return;
    end
    asking     = !m_in_flight && !m_holding;
    accepted   = asking && imem_bus.imem_req_ready;
    handed_off = m_holding && instr_ready;
    redir      = redirect_valid;
    if (handed_off) m_count = m_count + 1;
    m_mis = redir && ((redirect_target % 4) != 0);
    if (redir) m_pc = redirect_target - (redirect_target % 4);
    else if (handed_off) m_pc = m_pc + 4;
    if (accepted) begin
      m_in_flight = 1'b1;
      m_stale     = redir;
    end else if (m_in_flight) begin
      if (imem_bus.imem_rsp_valid) begin
        m_in_flight = 1'b0;
        if (!m_stale && !redir) begin
          m_holding = 1'b1;
          m_instr   = imem_bus.imem_rsp_data;
        end
        m_stale = 1'b0;
      end else if (redir) begin
        m_stale = 1'b1;
      end
    end else if (m_holding && (handed_off || redir)) begin
      m_holding = 1'b0;
    end
  endtask

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic rdy, input logic rsp, input logic [31:0] data,
                                input logic ir, input logic rv, input logic [31:0] tgt);
    imem_bus.imem_req_ready = rdy;
    imem_bus.imem_rsp_valid = rsp;
    imem_bus.imem_rsp_data  = data;
    instr_ready             = ir;
    redirect_valid          = rv;
    redirect_target         = tgt;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check_reset_state();
    check_output("reset req_valid",   {31'b0, imem_bus.imem_req_valid}, 32'h0);
    check_output("reset instr_valid", {31'b0, instr_valid}, 32'h0);
    check_output("reset instr",       instr, 32'h0000_0013);
    check_output("reset fetch_count", fetch_count, 32'h0);
    check_output("reset misalign",    {31'b0, misalign_err}, 32'h0);
    check_output("reset imem_addr",   imem_bus.imem_addr, 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check_reset_state();
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic fetch_to_hold(input logic [31:0] data);
    apply_stimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    apply_stimulus(1'b0, 1'b1, data, 1'b0, 1'b0, 32'h0);
    tick();
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  typedef struct {
    logic        rdy;
    logic        rsp;
    logic        ir;
    logic [31:0] data;
    logic        exp_rv;
    logic        exp_iv;
    logic [31:0] exp_addr;
    logic [31:0] exp_instr;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] held;
    vecs[0] = '{1'b1, 1'b0, 1'b1, 32'h0,          1'b0, 1'b0, 32'h0, 32'h0,          32'd0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 32'h0050_0093,  1'b0, 1'b1, 32'h0, 32'h0050_0093,  32'd0};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 32'h0,          1'b1, 1'b0, 32'h4, 32'h0,          32'd1};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 32'h0,          1'b0, 1'b0, 32'h4, 32'h0,          32'd1};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 32'h4020_8133,  1'b0, 1'b1, 32'h4, 32'h4020_8133,  32'd1};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 32'h0,          1'b1, 1'b0, 32'h8, 32'h0,          32'd2};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 32'h0,          1'b0, 1'b0, 32'h8, 32'h0,          32'd2};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 32'h00C1_2183,  1'b0, 1'b1, 32'h8, 32'h00C1_2183,  32'd2};
    vecs[8] = '{1'b1, 1'b0, 1'b1, 32'h0,          1'b1, 1'b0, 32'hC, 32'h0,          32'd3};

    // Steady fetch with an always-ready memory and decoder
    do_reset();
    check_output("t1 first req_valid", {31'b0, imem_bus.imem_req_valid}, 32'h1);
    check_output("t1 first addr", imem_bus.imem_addr, 32'h0);
    for (int i = 0; i < 9; i++) begin
      apply_stimulus(vecs[i].rdy, vecs[i].rsp, vecs[i].data, vecs[i].ir, 1'b0, 32'h0);
      tick();
      check_output($sformatf("t1[%0d] req_valid", i), {31'b0, imem_bus.imem_req_valid}, {31'b0, vecs[i].exp_rv});
      check_output($sformatf("t1[%0d] instr_valid", i), {31'b0, instr_valid}, {31'b0, vecs[i].exp_iv});
      check_output($sformatf("t1[%0d] imem_addr", i), imem_bus.imem_addr, vecs[i].exp_addr);
      check_output($sformatf("t1[%0d] pc_plus4", i), pc_plus4, vecs[i].exp_addr + 32'd4);
      check_output($sformatf("t1[%0d] fetch_count", i), fetch_count, vecs[i].exp_cnt);
      if (vecs[i].exp_iv) begin
        check_output($sformatf("t1[%0d] instr", i), instr, vecs[i].exp_instr);
        check_output($sformatf("t1[%0d] pc_out", i), pc_out, vecs[i].exp_addr);
        check_output($sformatf("t1[%0d] op", i), {25'b0, op}, vecs[i].exp_instr & 32'h7F);
        check_output($sformatf("t1[%0d] funct3", i), {29'b0, funct3}, (vecs[i].exp_instr >> 12) & 32'h7);
        check_output($sformatf("t1[%0d] funct7", i), {25'b0, funct7}, vecs[i].exp_instr >> 25);
      end
    end

    // Decoder backpressure while an instruction is held
    do_reset();
    held = 32'h00A0_0093;
    fetch_to_hold(held);
    apply_stimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_output("t2 held instr_valid", {31'b0, instr_valid}, 32'h1);
      check_output("t2 held instr", instr, held);
      check_output("t2 held pc_out", pc_out, 32'h0);
      check_output("t2 no new request", {31'b0, imem_bus.imem_req_valid}, 32'h0);
    end
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    tick();
    check_output("t2 release count", fetch_count, 32'd1);
    check_output("t2 release instr_valid", {31'b0, instr_valid}, 32'h0);
    check_output("t2 next addr", imem_bus.imem_addr, 32'h4);
    check_output("t2 next req_valid", {31'b0, imem_bus.imem_req_valid}, 32'h1);

    // Redirect while waiting; the late response must be dropped
    do_reset();
    apply_stimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    tick();
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h100);
    tick();
    check_output("t3 redirect instr_valid", {31'b0, instr_valid}, 32'h0);
    check_output("t3 redirect req_valid", {31'b0, imem_bus.imem_req_valid}, 32'h0);
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    tick();
    check_output("t3 gap instr_valid", {31'b0, instr_valid}, 32'h0);
    apply_stimulus(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
    tick();
    check_output("t3 dropped instr_valid", {31'b0, instr_valid}, 32'h0);
    check_output("t3 refetch req_valid", {31'b0, imem_bus.imem_req_valid}, 32'h1);
    check_output("t3 refetch addr", imem_bus.imem_addr, 32'h100);
    check_output("t3 count", fetch_count, 32'd0);

    // Redirect while holding, consumed and not consumed
    do_reset();
    fetch_to_hold(32'h0000_0033);
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h200);
    tick();
    check_output("t4a count", fetch_count, 32'd1);
    check_output("t4a addr", imem_bus.imem_addr, 32'h200);
    check_output("t4a req_valid", {31'b0, imem_bus.imem_req_valid}, 32'h1);
    do_reset();
    fetch_to_hold(32'h0000_0033);
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h200);
    tick();
    check_output("t4b count", fetch_count, 32'd0);
    check_output("t4b addr", imem_bus.imem_addr, 32'h200);
    check_output("t4b instr_valid", {31'b0, instr_valid}, 32'h0);

    // Misaligned redirect target
    do_reset();
    check_output("t5 before misalign", {31'b0, misalign_err}, 32'h0);
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h103);
    tick();
    check_output("t5 aligned addr", imem_bus.imem_addr, 32'h100);
    check_output("t5 misalign pulse", {31'b0, misalign_err}, 32'h1);
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    check_output("t5 misalign cleared", {31'b0, misalign_err}, 32'h0);
    check_output("t5 addr kept", imem_bus.imem_addr, 32'h100);

    // Asynchronous reset during an outstanding fetch
    do_reset();
    fetch_to_hold(32'h0010_0113);
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    tick();
    check_output("t6 pre count", fetch_count, 32'd1);
    apply_stimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_reset_state();
    apply_stimulus(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check_output("t6 restart req_valid", {31'b0, imem_bus.imem_req_valid}, 32'h1);
    check_output("t6 restart addr", imem_bus.imem_addr, 32'h0);
    check_output("t6 restart instr_valid", {31'b0, instr_valid}, 32'h0);
    tick();
    check_output("t6 ignored rsp instr_valid", {31'b0, instr_valid}, 32'h0);
    check_output("t6 ignored rsp instr", instr, 32'h0000_0013);

    // Random traffic against the reference model
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] tgt;
      tgt = $urandom_range(0, 32'h0000_0FFF);
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFFC | ($urandom & 32'h3);
      apply_stimulus($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, $urandom,
                     $urandom_range(0, 2) != 0, $urandom_range(0, 9) == 0, tgt);
      tick();
      check_output("rnd req_valid", {31'b0, imem_bus.imem_req_valid},
                   {31'b0, m_started && !m_in_flight && !m_holding});
      check_output("rnd instr_valid", {31'b0, instr_valid}, {31'b0, m_holding});
      check_output("rnd imem_addr", imem_bus.imem_addr, m_pc);
      check_output("rnd pc_out", pc_out, m_pc);
      check_output("rnd pc_plus4", pc_plus4, m_pc + 32'd4);
      check_output("rnd fetch_count", fetch_count, m_count);
      check_output("rnd misalign", {31'b0, misalign_err}, {31'b0, m_mis});
      if (m_holding) begin
        check_output("rnd instr", instr, m_instr);
        check_output("rnd op", {25'b0, op}, m_instr % 128);
        check_output("rnd funct3", {29'b0, funct3}, (m_instr / 4096) % 8);
        check_output("rnd funct7", {25'b0, funct7}, m_instr / 32'h0200_0000);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
